// File: rtl/rf_sched_pkg.sv
// Shared types for the register-file access scheduler: FSM states, op-select and registered output bundle.
package rf_sched_pkg;

    localparam logic [4:0] RA_REG = 5'd31;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WB        = 3'd1,
        ST_CALL_SAVE = 3'd2,
        ST_CALL_PUSH = 3'd3,
        ST_RET_PULL  = 3'd4,
        ST_RET_DONE  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_WB   = 2'd1,
        OP_CALL = 2'd2,
        OP_RET  = 2'd3
    } op_e;

    typedef struct packed {
        logic        wb_gnt;
        logic        call_done;
        logic        ret_done;
        logic        stack_err;
        logic [4:0]  write_reg;
        logic [31:0] write_data;
        logic        reg_write;
        logic        pc_store;
        logic        push;
        logic        pull;
        logic        busy;
    } sched_out_t;

endpackage

// File: rtl/rf_sched_pick.sv
// Combinational op selector: ret > call > wb, except an aged writeback jumps to the front.
module rf_sched_pick
    import rf_sched_pkg::*;
(
    input  logic wb_req,
    input  logic call_req,
    input  logic ret_req,
    input  logic wb_aged,
    output op_e  op
);

    always_comb begin
        op = OP_NONE;
        if (wb_req && wb_aged) begin
            op = OP_WB;
        end else if (ret_req) begin
            op = OP_RET;
        end else if (call_req) begin
            op = OP_CALL;
        end else if (wb_req) begin
            op = OP_WB;
        end
    end

endmodule

// File: rtl/rf_access_sched.sv
// Scheduler for writebacks, calls and returns into the RegisterFile and its return stack.
// Optional writeback aging is enabled by defining RF_SCHED_AGING_EN.
module rf_access_sched
    import rf_sched_pkg::*;
#(
    parameter  int STACK_DEPTH = 8,
    parameter  int AGE_LIMIT   = 4,
    localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wb_req,
    input  logic [4:0]         wb_reg,
    input  logic [31:0]        wb_data,
    output logic               wb_gnt,
    input  logic               call_req,
    input  logic [31:0]        call_pc,
    output logic               call_done,
    input  logic               ret_req,
    output logic               ret_done,
    output logic               stack_err,
    output logic [4:0]         WriteReg,
    output logic [31:0]        WriteData,
    output logic               Reg_write_Control,
    output logic               PC_Store,
    output logic               PUSH_Stack,
    output logic               PULL_Stack,
    output logic               busy,
    output logic [2:0]         state_dbg,
    output logic [DEPTH_W-1:0] depth_dbg
);

    // Handshake: a request (with its payload) is held until its gnt/done pulse. The request is
    // sampled again at the edge that ends that pulse, so a requester that still holds it then is
    // asking for another operation; drop it during the pulse cycle to issue exactly one.

    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);

    state_e               state_q, state_d;
    logic [DEPTH_W-1:0]   depth_q, depth_d;
    sched_out_t           out_q, out_d;
    op_e                  op;
    logic                 wb_aged;
    logic                 pick_point;

`ifdef RF_SCHED_AGING_EN
    localparam int AGE_W = $clog2(AGE_LIMIT + 1);
    logic [AGE_W-1:0] age_q, age_d;

    // Saturates at the limit so a long wait never wraps back to "young".
    always_comb begin
        age_d = age_q;
        if (out_q.wb_gnt) begin
            age_d = '0;
        end else if (wb_req && (age_q < AGE_W'(AGE_LIMIT))) begin
            age_d = age_q + 1'b1;
        end
    end

    assign wb_aged = (age_q >= AGE_W'(AGE_LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) age_q <= '0;
        else        age_q <= age_d;
    end
`else
    assign wb_aged = 1'b0;
`endif

    rf_sched_pick u_pick (
        .wb_req   (wb_req),
        .call_req (call_req),
        .ret_req  (ret_req),
        .wb_aged  (wb_aged),
        .op       (op)
    );

    // Terminal cycles of every sequence may launch the next op directly (no idle gap).
    assign pick_point = (state_q == ST_IDLE) || (state_q == ST_WB) ||
                        (state_q == ST_CALL_PUSH) || (state_q == ST_RET_DONE) ||
                        ((state_q == ST_CALL_SAVE) && out_q.stack_err);

    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        out_d   = '0;
        if (pick_point) begin
            unique case (op)
                OP_WB: begin
                    state_d          = ST_WB;
                    out_d.wb_gnt     = 1'b1;
                    out_d.write_reg  = wb_reg;
                    out_d.write_data = wb_data;
                    out_d.reg_write  = (wb_reg != 5'd0);
                end
                OP_CALL: begin
                    state_d          = ST_CALL_SAVE;
                    out_d.pc_store   = 1'b1;
                    out_d.write_reg  = RA_REG;
                    out_d.write_data = call_pc;
                    out_d.reg_write  = 1'b1;
                    if (depth_q == DEPTH_FULL) begin
                        out_d.call_done = 1'b1;
                        out_d.stack_err = 1'b1;
                    end
                end
                OP_RET: begin
                    if (depth_q == '0) begin
                        state_d         = ST_RET_DONE;
                        out_d.ret_done  = 1'b1;
                        out_d.stack_err = 1'b1;
                    end else begin
                        state_d         = ST_RET_PULL;
                        out_d.pull      = 1'b1;
                        out_d.reg_write = 1'b1;
                        out_d.write_reg = RA_REG;
                        depth_d         = depth_q - 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            unique case (state_q)
                ST_CALL_SAVE: begin
                    state_d          = ST_CALL_PUSH;
                    out_d.push       = 1'b1;
                    out_d.reg_write  = 1'b1;
                    out_d.call_done  = 1'b1;
                    out_d.write_reg  = RA_REG;
                    out_d.write_data = call_pc;
                    depth_d          = depth_q + 1'b1;
                end
                ST_RET_PULL: begin
                    state_d        = ST_RET_DONE;
                    out_d.ret_done = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        out_d.busy = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            depth_q <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            out_q   <= out_d;
        end
    end

    assign wb_gnt            = out_q.wb_gnt;
    assign call_done         = out_q.call_done;
    assign ret_done          = out_q.ret_done;
    assign stack_err         = out_q.stack_err;
    assign WriteReg          = out_q.write_reg;
    assign WriteData         = out_q.write_data;
    assign Reg_write_Control = out_q.reg_write;
    assign PC_Store          = out_q.pc_store;
    assign PUSH_Stack        = out_q.push;
    assign PULL_Stack        = out_q.pull;
    assign busy              = out_q.busy;
    assign state_dbg         = state_q;
    assign depth_dbg         = depth_q;

endmodule
